if_fetch_unit: RTL and testbench

- Instruction-fetch stage. Owns the PC and a single-outstanding-request handshake to the instruction memory/I-cache.
- Produces the instruction/PC pair plus the write-enable and flush controls consumed by the IF/ID pipeline register.
- Sits between the I-cache and IF/ID. Takes stall from the hazard unit and branch/jump redirects from the resolve stage.

---
 rtl/if_fetch_unit.sv | 135 +++++++++++++
 tb/tb_if_fetch_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request outstanding to the
// I-cache and feeds the instruction/PC pair plus load/flush controls to IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        icache_req_o,
  output logic [31:0] icache_addr_o,
  input  logic        icache_valid_i,
  input  logic [31:0] icache_rdata_i,
  output logic [31:0] Instr_o,
  output logic [31:0] PC_o,
  output logic        IF_ID_Write_o,
  output logic        flush_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_HOLD = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t            state_r, state_nxt;
  logic [XLEN-1:0]   pc_r, pc_nxt;
  logic [XLEN-1:0]   buf_r, buf_nxt;
  logic [XLEN-1:0]   pc_inc;
  logic [XLEN-1:0]   redirect_tgt;
  logic              unused_redirect_lsbs;

  assign pc_inc               = pc_r + XLEN'(4);
  assign redirect_tgt         = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // State, PC and hold-buffer registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_WAIT;
      pc_r    <= RESET_PC;
      buf_r   <= '0;
    end else begin
      state_r <= state_nxt;
      pc_r    <= pc_nxt;
      buf_r   <= buf_nxt;
    end
  end

  // Next-state and combinational outputs; redirect > response > stall
  always_comb begin
    state_nxt     = state_r;
    pc_nxt        = pc_r;
    buf_nxt       = buf_r;
    icache_req_o  = 1'b0;
    icache_addr_o = pc_r;
    Instr_o       = '0;
    PC_o          = pc_r;
    IF_ID_Write_o = 1'b0;
    flush_o       = 1'b0;

    case (state_r)
      ST_WAIT: begin
        icache_req_o = 1'b1;
        if (redirect_i) begin
          IF_ID_Write_o = 1'b1;
          flush_o       = 1'b1;
          pc_nxt        = redirect_tgt;
          state_nxt     = icache_valid_i ? ST_WAIT : ST_DROP;
        end else if (icache_valid_i) begin
          if (!stall_i) begin
            Instr_o       = icache_rdata_i;
            IF_ID_Write_o = 1'b1;
            pc_nxt        = pc_inc;
          end else begin
            buf_nxt   = icache_rdata_i;
            state_nxt = ST_HOLD;
          end
        end else if (!stall_i) begin
          IF_ID_Write_o = 1'b1;
          flush_o       = 1'b1;
        end
      end

      ST_HOLD: begin
        // Any response seen here is a protocol error and is ignored
        if (redirect_i) begin
          IF_ID_Write_o = 1'b1;
          flush_o       = 1'b1;
          pc_nxt        = redirect_tgt;
          state_nxt     = ST_WAIT;
        end else begin
          Instr_o = buf_r;
          if (!stall_i) begin
            IF_ID_Write_o = 1'b1;
            pc_nxt        = pc_inc;
            state_nxt     = ST_WAIT;
          end
        end
      end

      ST_DROP: begin
        if (redirect_i) begin
          IF_ID_Write_o = 1'b1;
          flush_o       = 1'b1;
          pc_nxt        = redirect_tgt;
        end else begin
          IF_ID_Write_o = ~stall_i;
          flush_o       = ~stall_i;
        end
        if (icache_valid_i) begin
          state_nxt = ST_WAIT;
        end
      end

      default: begin
        state_nxt = ST_WAIT;
      end
    endcase

    // Reset forces every output low without waiting for a clock
    if (!rst_i) begin
      icache_req_o  = 1'b0;
      icache_addr_o = '0;
      Instr_o       = '0;
      PC_o          = '0;
      IF_ID_Write_o = 1'b0;
      flush_o       = 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stimulus pushes expected deliveries into a
// scoreboard queue; a monitor pops and compares on every real IF/ID load.
module tb_if_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        icache_req_o;
  logic [31:0] icache_addr_o;
  logic        icache_valid_i;
  logic [31:0] icache_rdata_i;
  logic [31:0] Instr_o;
  logic [31:0] PC_o;
  logic        IF_ID_Write_o;
  logic        flush_o;

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] exp_q[$];   // {pc, instr}

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .icache_req_o  (icache_req_o),
    .icache_addr_o (icache_addr_o),
    .icache_valid_i(icache_valid_i),
    .icache_rdata_i(icache_rdata_i),
    .Instr_o       (Instr_o),
    .PC_o          (PC_o),
    .IF_ID_Write_o (IF_ID_Write_o),
    .flush_o       (flush_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  // Drive one cycle's inputs, then settle to the negedge for sampling
  task automatic drive(input logic v, input logic [31:0] d, input logic st,
                       input logic rd, input logic [31:0] rpc);
    icache_valid_i = v;
    icache_rdata_i = d;
    stall_i        = st;
    redirect_i     = rd;
    redirect_pc_i  = rpc;
    @(negedge clk_i);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    exp_q.push_back({pc, ins});
  endtask

  // Monitor: every non-bubble IF/ID load must match the next expected delivery
  always @(negedge clk_i) begin
    if (rst_i === 1'b1 && IF_ID_Write_o === 1'b1 && flush_o === 1'b0) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_delivery: got pc %08h instr %08h expected none", PC_o, Instr_o);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("deliver_pc", PC_o, e[63:32]);
        chk("deliver_instr", Instr_o, e[31:0]);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rst_req", 32'(icache_req_o), 32'd0);
    chk("rst_write", 32'(IF_ID_Write_o), 32'd0);
    chk("rst_flush", 32'(flush_o), 32'd0);
    chk("rst_instr", Instr_o, 32'h0);
    chk("rst_pc", PC_o, 32'h0);
    tick();
    rst_i = 1'b1;

    // First request at RESET_PC; a cycle of bubble, then the response
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("boot_req", 32'(icache_req_o), 32'd1);
    chk("boot_addr", icache_addr_o, 32'h0);
    chk("boot_bubble_w", 32'(IF_ID_Write_o), 32'd1);
    chk("boot_bubble_f", 32'(flush_o), 32'd1);
    tick();
    push(32'h0, 32'h0050_0093);
    drive(1'b1, 32'h0050_0093, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("addr_after_0", icache_addr_o, 32'h4);
    tick();
    push(32'h4, 32'h0010_0113);
    drive(1'b1, 32'h0010_0113, 1'b0, 1'b0, 32'h0);
    tick();

    // Response at PC 8 under a 3-cycle stall
    drive(1'b1, 32'hDEAD_0008, 1'b1, 1'b0, 32'h0);
    chk("stall0_w", 32'(IF_ID_Write_o), 32'd0);
    tick();
    for (int i = 1; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("hold_w", 32'(IF_ID_Write_o), 32'd0);
      chk("hold_req", 32'(icache_req_o), 32'd0);
      tick();
    end
    push(32'h8, 32'hDEAD_0008);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("addr_after_hold", icache_addr_o, 32'hC);
    chk("req_after_hold", 32'(icache_req_o), 32'd1);

    // Four-cycle memory latency at PC 12: three bubbles, then delivery
    for (int i = 1; i < 3; i++) begin
      tick();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      chk("lat_bubble_w", 32'(IF_ID_Write_o), 32'd1);
      chk("lat_bubble_f", 32'(flush_o), 32'd1);
    end
    tick();
    push(32'hC, 32'h0000_C0DE);
    drive(1'b1, 32'h0000_C0DE, 1'b0, 1'b0, 32'h0);
    tick();

    // Redirect while the request at 16 is outstanding
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("addr_16", icache_addr_o, 32'h10);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
    chk("redir_w", 32'(IF_ID_Write_o), 32'd1);
    chk("redir_f", 32'(flush_o), 32'd1);
    chk("redir_instr", Instr_o, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("drop_req", 32'(icache_req_o), 32'd0);
    chk("drop_f", 32'(flush_o), 32'd1);
    tick();
    drive(1'b1, 32'hBAD0_0010, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("addr_redir", icache_addr_o, 32'h100);
    tick();
    push(32'h100, 32'h1111_0100);
    drive(1'b1, 32'h1111_0100, 1'b0, 1'b0, 32'h0);
    tick();

    // Redirect coincident with response and stall
    drive(1'b1, 32'hBAD0_0104, 1'b1, 1'b1, 32'h0000_0200);
    chk("coinc_w", 32'(IF_ID_Write_o), 32'd1);
    chk("coinc_f", 32'(flush_o), 32'd1);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("coinc_addr", icache_addr_o, 32'h200);
    chk("coinc_req", 32'(icache_req_o), 32'd1);

    // PC wrap: redirect to the top word, drain DROP, deliver, wrap to 0
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    tick();
    drive(1'b1, 32'hBAD0_0200, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("top_addr", icache_addr_o, 32'hFFFF_FFFC);
    tick();
    push(32'hFFFF_FFFC, 32'h7777_FFFC);
    drive(1'b1, 32'h7777_FFFC, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr", icache_addr_o, 32'h0);
    tick();

    // Reset while in HOLD clears outputs immediately
    drive(1'b1, 32'h5555_0000, 1'b1, 1'b0, 32'h0);
    tick();
    rst_i = 1'b0;
    #1;
    chk("hold_rst_w", 32'(IF_ID_Write_o), 32'd0);
    chk("hold_rst_f", 32'(flush_o), 32'd0);
    chk("hold_rst_instr", Instr_o, 32'h0);
    chk("hold_rst_req", 32'(icache_req_o), 32'd0);
    tick();
    rst_i = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("post_rst_req", 32'(icache_req_o), 32'd1);
    chk("post_rst_addr", icache_addr_o, 32'h0);
    chk("post_rst_flush", 32'(flush_o), 32'd1);
    tick();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
